bus_responder_8227: RTL

Synthesizable memory-side responder for the top8227 CPU bus. It decodes the 16-bit address from the CPU, serves reads from an internal RAM bank and a writable vector table, and commits writes. It stalls slow-region accesses by deasserting `ready` for a programmable number of wait states. It sits opposite top8227 on the external bus and replaces the behavioral memory model at chip and FPGA level.

---
 rtl/bus_responder_8227.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/bus_responder_8227.sv
// bus_responder_8227: memory-side responder for the top8227 CPU bus.
// Decodes the 16-bit CPU address into an internal RAM bank, a writable
// six-byte vector table (FFFA-FFFF) and unmapped space. Slow-region
// accesses can be stalled by deasserting ready for a fixed number of
// wait states.
// Optional feature macro: BUS_RESPONDER_WAIT_EN (wait-state FSM). When it
// is undefined, ready is tied high and SLOW_BASE/WAIT_CYCLES are ignored.
module bus_responder_8227 #(
   parameter int          RAM_AW      = 10,
   parameter logic [15:0] SLOW_BASE   = 16'h8000,
   parameter int          WAIT_CYCLES = 2,
   parameter logic [15:0] RST_VEC     = 16'hCCDD,
   parameter logic [15:0] NMI_VEC     = 16'h0000,
   parameter logic [15:0] IRQ_VEC     = 16'h0000,
   parameter logic [7:0]  OPEN_BUS    = 8'hEA
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic [7:0]  addressBusHigh,
   input  logic [7:0]  addressBusLow,
   input  logic        readNotWrite,
   input  logic [7:0]  dataBusOutput,
   input  logic        dataBusEnable,
   input  logic        sync,
   output logic [7:0]  dataBusInput,
   output logic        ready,
   output logic [15:0] fetchCount,
   output logic        busError
);

   localparam int RAM_WORDS = 1 << RAM_AW;

   logic [15:0]       w_addr;
   logic              w_is_vec;
   logic              w_is_ram;
   logic [2:0]        w_vec_idx;
   logic [RAM_AW-1:0] w_ram_idx;
   logic [7:0]        w_rd_data;
   logic              w_ready;
   logic              w_commit;

   logic [7:0]        r_ram [0:RAM_WORDS-1];
   logic [7:0]        r_vec [0:5];
   logic [7:0]        r_hold;
   logic [15:0]       r_fetch;
   logic              r_bus_err;

   assign w_addr    = {addressBusHigh, addressBusLow};
   // The vector table wins over RAM when both decode the same address.
   assign w_is_vec  = (w_addr >= 16'hFFFA);
   assign w_is_ram  = !w_is_vec && ({16'h0000, w_addr} < (32'd1 << RAM_AW));
   // FFFA..FFFF map to vector slots 0..5.
   assign w_vec_idx = w_addr[2:0] - 3'd2;
   assign w_ram_idx = w_addr[RAM_AW-1:0];

   // Asynchronous read decode: vector table, RAM, or open-bus value.
   always_comb begin
      w_rd_data = OPEN_BUS;
      if (w_is_vec) begin
         w_rd_data = r_vec[w_vec_idx];
      end else if (w_is_ram) begin
         w_rd_data = r_ram[w_ram_idx];
      end else begin
         w_rd_data = OPEN_BUS;
      end
   end

   // A write only lands on the edge where the access completes.
   assign w_commit = w_ready && !readNotWrite && dataBusEnable;

`ifdef BUS_RESPONDER_WAIT_EN
   typedef enum logic {ST_RUN = 1'b0, ST_WAIT = 1'b1} state_t;

   localparam logic       WAIT_ON   = (WAIT_CYCLES > 0);
   localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic [15:0] r_last_addr;
   logic        r_last_rnw;
   logic        r_first;
   logic        w_slow;
   logic        w_new;

   assign w_slow = (w_addr >= SLOW_BASE);
   assign w_new  = (w_addr != r_last_addr) || (readNotWrite != r_last_rnw) || r_first;

   // Combinational ready: stall a fresh slow access in RUN, count down in WAIT.
   always_comb begin
      w_ready = 1'b1;
      case (r_state)
         ST_RUN:  w_ready = !(w_slow && w_new && WAIT_ON);
         ST_WAIT: w_ready = (r_cnt == 4'd0);
         default: w_ready = 1'b1;
      endcase
   end

   // Wait-state FSM; a bus change during WAIT still completes after the count.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state     <= ST_RUN;
         r_cnt       <= 4'd0;
         r_last_addr <= 16'h0000;
         r_last_rnw  <= 1'b1;
         r_first     <= 1'b1;
      end else begin
         case (r_state)
            ST_RUN: begin
               r_last_addr <= w_addr;
               r_last_rnw  <= readNotWrite;
               r_first     <= 1'b0;
               if (!w_ready) begin
                  r_state <= ST_WAIT;
                  r_cnt   <= WAIT_LOAD;
               end else begin
                  r_state <= ST_RUN;
               end
            end
            ST_WAIT: begin
               if (r_cnt != 4'd0) begin
                  r_cnt <= r_cnt - 4'd1;
               end else begin
                  r_state <= ST_RUN;
               end
            end
            default: begin
               r_state <= ST_RUN;
               r_cnt   <= 4'd0;
            end
         endcase
      end
   end
`else
   logic w_unused_cfg;

   assign w_ready      = 1'b1;
   assign w_unused_cfg = ^{SLOW_BASE, WAIT_CYCLES};
`endif

   // RAM bank write port; contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (w_commit && w_is_ram) begin
         r_ram[w_ram_idx] <= dataBusOutput;
      end
   end

   // Vector table, read-data hold, sticky bus error and fetch counter.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_vec[0]  <= NMI_VEC[7:0];
         r_vec[1]  <= NMI_VEC[15:8];
         r_vec[2]  <= RST_VEC[7:0];
         r_vec[3]  <= RST_VEC[15:8];
         r_vec[4]  <= IRQ_VEC[7:0];
         r_vec[5]  <= IRQ_VEC[15:8];
         r_hold    <= 8'h00;
         r_fetch   <= 16'h0000;
         r_bus_err <= 1'b0;
      end else begin
         if (w_commit && w_is_vec) begin
            r_vec[w_vec_idx] <= dataBusOutput;
         end
         if (w_commit && !w_is_vec && !w_is_ram) begin
            r_bus_err <= 1'b1;
         end
         if (readNotWrite) begin
            r_hold <= w_rd_data;
         end
         if (w_ready && sync && (r_fetch != 16'hFFFF)) begin
            r_fetch <= r_fetch + 16'd1;
         end
      end
   end

   assign dataBusInput = readNotWrite ? w_rd_data : r_hold;
   assign ready        = w_ready;
   assign fetchCount   = r_fetch;
   assign busError     = r_bus_err;

endmodule
